// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam int unsigned ALIGN_BITS = 3;

  // Reject causes, in check priority order
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CONFLICT = 2'd1;
  localparam logic [1:0] ERR_ALIGN    = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter with zero flag, used to time wait states.
module dmem_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero_c
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: wait states, one-cycle
// mem_ready completion and rejection of conflicting/misaligned/out-of-range requests.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int unsigned UPPER_W = ADDR_W - ALIGN_BITS;

  state_t state_q, state_d;

  logic              is_store_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             cnt_load_c, cnt_dec_c, cnt_zero_c;
  logic [CNT_W-1:0] cnt_val_c, cnt_q;

  logic              accept_c, fire_c, err_c;
  logic              op_store_c;
  logic [IDX_W-1:0]  op_idx_c;
  logic [DATA_W-1:0] op_wdata_c;
  logic              conflict_c, misaligned_c, range_c;

  assign conflict_c   = MemRead & MemWrite;
  assign misaligned_c = (mem_addr[ALIGN_BITS-1:0] != '0);
  assign range_c      = (mem_addr[ADDR_W-1:ALIGN_BITS] >= UPPER_W'(DEPTH));

  dmem_wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .dec      (cnt_dec_c),
    .load_val (cnt_val_c),
    .count    (cnt_q),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // fire_c marks the edge that raises mem_ready; the op_* values come straight
  // from the inputs when a 1-cycle latency fires on the acceptance edge itself.
  always_comb begin
    state_d    = state_q;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    cnt_val_c  = '0;
    accept_c   = 1'b0;
    fire_c     = 1'b0;
    err_c      = 1'b0;
    op_store_c = is_store_q;
    op_idx_c   = idx_q;
    op_wdata_c = wdata_q;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (conflict_c || misaligned_c || range_c) begin
            state_d = ERR;
            err_c   = 1'b1;
          end else begin
            state_d    = WAIT;
            accept_c   = 1'b1;
            op_store_c = MemWrite;
            op_idx_c   = mem_addr[ALIGN_BITS +: IDX_W];
            op_wdata_c = write_data;
            cnt_load_c = 1'b1;
            cnt_val_c  = MemWrite ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
            fire_c     = MemWrite ? (WRITE_LAT == 1) : (READ_LAT == 1);
          end
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          state_d = IDLE;
        end else begin
          cnt_dec_c = 1'b1;
          fire_c    = (cnt_q == CNT_W'(1));
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data  <= '0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      busy       <= 1'b0;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      mem_ready <= fire_c | err_c;
      mem_err   <= err_c;
      busy      <= (state_d != IDLE);
      if (err_c) begin
        read_data <= '0;
      end else if (fire_c && !op_store_c) begin
        read_data <= mem[op_idx_c];
      end
      if (accept_c) begin
        is_store_q <= op_store_c;
        idx_q      <= op_idx_c;
        wdata_q    <= op_wdata_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fire_c && op_store_c) begin
      mem[op_idx_c] <= op_wdata_c;
    end
  end

endmodule
